// File: rtl/rotary_multi_driver_if.sv
// Event bus between the rotary front end and the control center.
// Encoder pins and the consumer's ready come in; the arbitrated event
// (start/action/ch) and per-channel overflow pulses go out.
// Handshake: an event is presented by a one-cycle start pulse with action/ch
// valid in that cycle. A start is only raised in a cycle whose preceding
// edge saw ready = 1, and never in two consecutive cycles. action/ch hold
// their value until the next start.
interface rotary_multi_driver_if #(
    parameter int N_CH = 2,
    parameter int CH_W = 1
);
    logic [N_CH-1:0] rotary_a;
    logic [N_CH-1:0] rotary_b;
    logic [N_CH-1:0] rotary_press;
    logic            ready;
    logic            start;
    logic [1:0]      action;
    logic [CH_W-1:0] ch;
    logic [N_CH-1:0] overflow;

    // Side that drives the encoder pins and consumes events
    modport master (
        output rotary_a, rotary_b, rotary_press, ready,
        input  start, action, ch, overflow
    );

    // Side that decodes the encoders and issues events
    modport slave (
        input  rotary_a, rotary_b, rotary_press, ready,
        output start, action, ch, overflow
    );
endinterface

// File: rtl/rotary_multi_driver.sv
// Multi-channel rotary encoder front end.
// Each channel's A/B/press pins are synchronised and debounced. Detents and
// press edges feed a signed, saturating pending-step accumulator and a press
// flag. A round-robin arbiter drains the pending work one event at a time.
module rotary_multi_driver #(
    parameter int N_CH       = 2,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rotary_multi_driver_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NP   = 3 * N_CH;
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int AW   = CNT_W + 2;
    localparam int AMAX = (1 << (CNT_W - 1)) - 1;

    // Pin order in the flattened vectors: {press, b, a}; A/B idle high
    localparam logic [NP-1:0]        IDLE     = {{N_CH{1'b0}}, {(2 * N_CH){1'b1}}};
    localparam logic [DW-1:0]        DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic signed [AW-1:0] SAT_HI   = AW'(AMAX);
    localparam logic signed [AW-1:0] SAT_LO   = AW'(-AMAX);
    localparam logic signed [AW-1:0] S_ONE    = AW'(1);
    localparam logic signed [AW-1:0] S_NEG    = AW'(-1);
    localparam logic signed [AW-1:0] S_ZERO   = AW'(0);

    logic [NP-1:0]   raw;
    logic [NP-1:0]   sync1;
    logic [NP-1:0]   sync2;
    logic [NP-1:0]   deb;
    logic [DW-1:0]   deb_cnt [NP];

    logic [N_CH-1:0] deb_a;
    logic [N_CH-1:0] deb_b;
    logic [N_CH-1:0] deb_p;
    logic [N_CH-1:0] deb_a_d;
    logic [N_CH-1:0] deb_p_d;
    logic [N_CH-1:0] a_fall;
    logic [N_CH-1:0] p_rise;

    logic signed [CNT_W-1:0] acc     [N_CH];
    logic signed [CNT_W-1:0] acc_nxt [N_CH];
    logic [N_CH-1:0] press_pend;
    logic [N_CH-1:0] press_nxt;
    logic [N_CH-1:0] ovf_nxt;
    logic [N_CH-1:0] overflow_q;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] issue_press;
    logic [N_CH-1:0] issue_rot;

    logic [CH_W-1:0] rr;
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] ch_q;
    logic            found;
    logic            issue;
    logic            start_q;
    logic [1:0]      action_q;
    logic [1:0]      issue_action;
    int              idx;

    logic signed [AW-1:0] acc_ext;
    logic signed [AW-1:0] step;
    logic signed [AW-1:0] dec;
    logic signed [AW-1:0] sum;

    assign raw   = {bus.rotary_press, bus.rotary_b, bus.rotary_a};
    assign deb_a = deb[N_CH-1:0];
    assign deb_b = deb[2*N_CH-1:N_CH];
    assign deb_p = deb[NP-1:2*N_CH];

    // Two-flop synchroniser for every pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= IDLE;
            for (int i = 0; i < NP; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced A and press, for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_a_d <= {N_CH{1'b1}};
            deb_p_d <= '0;
        end else begin
            deb_a_d <= deb_a;
            deb_p_d <= deb_p;
        end
    end

    assign a_fall = deb_a_d & ~deb_a;
    assign p_rise = deb_p & ~deb_p_d;

    // Round-robin pick of the first channel with pending work, starting at rr
    always_comb begin
        found        = 1'b0;
        pick         = '0;
        idx          = 0;
        eligible     = '0;
        issue_action = 2'd0;
        for (int c = 0; c < N_CH; c++) begin
            eligible[c] = press_pend[c] | (acc[c] != '0);
        end
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr) + i) % N_CH;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
        // Only one issue per two cycles: start_q marks the cycle just issued
        issue = found & bus.ready & ~start_q;
        if (press_pend[pick]) begin
            issue_action = 2'd3;
        end else if (acc[pick][CNT_W-1]) begin
            issue_action = 2'd1;
        end else begin
            issue_action = 2'd2;
        end
    end

    // Per-channel next state: new step minus issued step, saturating
    always_comb begin
        acc_ext     = S_ZERO;
        step        = S_ZERO;
        dec         = S_ZERO;
        sum         = S_ZERO;
        ovf_nxt     = '0;
        press_nxt   = '0;
        issue_press = '0;
        issue_rot   = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc_nxt[c]     = acc[c];
            issue_press[c] = issue && (int'(pick) == c) && press_pend[c];
            issue_rot[c]   = issue && (int'(pick) == c) && !press_pend[c];
            acc_ext        = {{2{acc[c][CNT_W-1]}}, acc[c]};
            step           = a_fall[c] ? (deb_b[c] ? S_ONE : S_NEG) : S_ZERO;
            dec            = issue_rot[c] ? (acc[c][CNT_W-1] ? S_NEG : S_ONE) : S_ZERO;
            sum            = acc_ext + step - dec;
            if (sum > SAT_HI) begin
                acc_nxt[c] = SAT_HI[CNT_W-1:0];
                ovf_nxt[c] = 1'b1;
            end else if (sum < SAT_LO) begin
                acc_nxt[c] = SAT_LO[CNT_W-1:0];
                ovf_nxt[c] = 1'b1;
            end else begin
                acc_nxt[c] = sum[CNT_W-1:0];
            end
            // A new press edge in the issue cycle is a fresh press and stays pending
            press_nxt[c] = (press_pend[c] & ~issue_press[c]) | p_rise[c];
        end
    end

    // Pending work registers and overflow pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
            press_pend <= '0;
            overflow_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) acc[c] <= acc_nxt[c];
            press_pend <= press_nxt;
            overflow_q <= ovf_nxt;
        end
    end

    // Event output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            action_q <= 2'd0;
            ch_q     <= '0;
            rr       <= '0;
        end else begin
            start_q <= issue;
            if (issue) begin
                action_q <= issue_action;
                ch_q     <= pick;
                rr       <= (int'(pick) == N_CH - 1) ? '0 : pick + 1'b1;
            end
        end
    end

    assign bus.start    = start_q;
    assign bus.action   = action_q;
    assign bus.ch       = ch_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/rotary_multi_driver.md
Name: rotary_multi_driver

Overview:
- Parametrised successor to the single-encoder rotary front end: N_CH quadrature encoders with push buttons.
- Per input: 2-FF synchronisation, debounce, detent decode, plus a signed pending-step accumulator per channel.
- A round-robin arbiter issues one event at a time (action + channel + 1-cycle start) to the control center, throttled by a ready handshake so bursts of detents are never lost.

Parameters:
- N_CH, 2, number of encoder channels (1..8).
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a new input level (0.5 ms at 100 MHz); minimum 2.
- CNT_W, 4, width of the signed per-channel step accumulator; saturates at ±(2^(CNT_W-1)-1).
- CH_W, derived localparam = max(1, clog2(N_CH)).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rotary_a  in  N_CH  encoder A per channel, idle high.
- rotary_b  in  N_CH  encoder B per channel, idle high.
- rotary_press  in  N_CH  push button per channel, active high.
- ready  in  1  consumer can accept an event this cycle.
- start  out  1  one-cycle event strobe.
- action  out  2  0=none, 1=left, 2=right, 3=press; valid with start, held until the next start.
- ch  out  CH_W  channel of the event; valid with start, held until the next start.
- overflow  out  N_CH  one-cycle pulse when a channel accumulator saturates and a step is dropped.

Behaviour:
- Reset: synchronisers and debounced A/B = 1, debounced press = 0, counters = 0, accumulators = 0, press flags = 0, RR pointer = 0, start = 0, action = 0, ch = 0, overflow = 0.
- Debounce, per input: counter runs while the synced value differs from the debounced value and clears on any match. When the counter reaches DEB_CYCLES, the debounced value takes the synced value and the counter clears. Glitches shorter than DEB_CYCLES are never accepted.
- Detent decode: a debounced A falling edge with debounced B = 1 gives right (+1); with B = 0 gives left (-1). A rising edge gives no step.
- Press: a debounced press rising edge sets press_pend[ch]. A second press while pending is merged (no count).
- Accumulator update each cycle: acc += step_in − issued. Opposite directions cancel. If the result would exceed ±max, hold at ±max and pulse overflow[ch].
- Eligibility: a channel is eligible if press_pend is set or acc ≠ 0.
- Arbiter issue: when ready = 1 and start was 0 last cycle, pick the first eligible channel starting from the RR pointer and wrapping modulo N_CH.
  - For that channel, press takes precedence over rotation.
  - Issue start = 1, set action/ch, clear press_pend, or move acc one step toward 0.
  - RR pointer = chosen + 1 (wrapping).
- Minimum spacing between starts is 2 cycles. With ready = 0 nothing issues, and pending work accumulates.
- Same cycle, same channel, step_in and issue both occur: the net is applied. Example: acc = +1, new +1, issue right → acc = +1.
- Latency, idle and ready = 1: from input pin change to start = DEB_CYCLES + 4 cycles (2 sync + debounce + edge/acc register + issue register).
- Asynchronous reset mid-operation: all pending events are discarded; there is no start in the cycle after release.
- Simultaneous press and rotation on one channel: the press is issued first, rotation on the next eligible slot.

Test Plan (DEB_CYCLES=4, N_CH=2, CNT_W=4):
- Ch0 A falls with B=1, held 10 cycles → exactly one start with action=2, ch=0, exactly 8 cycles after the A edge; no event on the A rise.
- Ch1 A pulse low for 3 cycles (below DEB_CYCLES) → no start, accumulator stays 0.
- ready=0; ch0 gets 3 left detents, ch1 gets one press; then ready=1 → starts in order: (3,ch1)? No: the RR pointer is 0, so the order is (1,ch0), (3,ch1), (1,ch0), (1,ch0), spaced 2 cycles apart.
- ready=0; ch0 gets 9 right detents → acc saturates at +7, overflow[0] pulses twice, then exactly 7 right events after ready rises.
- ch0 right then left detent while ready=0 → acc returns to 0, no event issued.
- Assert rst_n=0 with acc[0]=+3 pending, then release → no start for 20 cycles, action=0, ch=0.
